// File: rtl/cpu_sys_pll_reset_sequencer.sv
// System PLL bring-up sequencer: pulses PLL reset, waits for lock with a timeout,
// qualifies lock as stable, then releases system reset. Failed attempts are retried
// up to a limit before a sticky fault is latched.
module cpu_sys_pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 17,
    parameter int unsigned RTY_W         = 2
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [RTY_W-1:0] retry_count
);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRIES);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [RTY_W-1:0] retry_nx;
    logic             attempt_fail;
    logic             lock_meta;
    logic             lock_s;
    logic             pll_rst_nx;
    logic             sys_rst_nx;
    logic             ready_nx;
    logic             fault_nx;

    // Two-flop synchronizer bringing the asynchronous lock indication into refclk.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // State, counters and registered outputs; outputs track the state being entered.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_RESET_PLL;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            retry_count <= retry_nx;
            pll_rst     <= pll_rst_nx;
            sys_rst     <= sys_rst_nx;
            ready       <= ready_nx;
            fault       <= fault_nx;
        end
    end

    // Next-state, counter and retry bookkeeping, plus output decode of the next state.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        retry_nx     = retry_count;
        attempt_fail = 1'b0;

        case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nx = S_WAIT_LOCK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = S_STABLE;
                    cnt_nx   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    attempt_fail = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    attempt_fail = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                    retry_nx = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                // Lock loss and a relock request in the same cycle give one restart.
                if (!lock_s || relock_req) begin
                    state_nx = S_RESET_PLL;
                    cnt_nx   = '0;
                end
            end
            S_FAULT: begin
                if (relock_req) begin
                    state_nx = S_RESET_PLL;
                    cnt_nx   = '0;
                    retry_nx = '0;
                end
            end
            default: begin
                state_nx = S_RESET_PLL;
                cnt_nx   = '0;
            end
        endcase

        // A failed attempt either retries from the PLL reset or gives up.
        if (attempt_fail) begin
            cnt_nx = '0;
            if (retry_count == RETRY_MAX) begin
                state_nx = S_FAULT;
            end else begin
                state_nx = S_RESET_PLL;
                retry_nx = retry_count + RTY_W'(1);
            end
        end

        pll_rst_nx = (state_nx == S_RESET_PLL) || (state_nx == S_FAULT);
        sys_rst_nx = (state_nx != S_RUN);
        ready_nx   = (state_nx == S_RUN);
        fault_nx   = (state_nx == S_FAULT);
    end

endmodule

// File: tb/tb_cpu_sys_pll_reset_sequencer.sv
// Directed bench for the PLL reset sequencer with small timing parameters.
module tb_cpu_sys_pll_reset_sequencer;

    localparam int unsigned RST_CYCLES    = 4;
    localparam int unsigned LOCK_TIMEOUT  = 32;
    localparam int unsigned STABLE_CYCLES = 8;
    localparam int unsigned MAX_RETRIES   = 2;
    localparam int unsigned CNT_W         = 17;
    localparam int unsigned RTY_W         = 2;

    logic             refclk;
    logic             rst;
    logic             pll_locked;
    logic             relock_req;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic             fault;
    logic [RTY_W-1:0] retry_count;

    int errors = 0;
    int checks = 0;
    int n;
    int hi;

    cpu_sys_pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (CNT_W),
        .RTY_W        (RTY_W)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Number of consecutive samples (starting now) with pll_rst high.
    task automatic high_len(output int len);
        len = 0;
        while (pll_rst === 1'b1 && len < 200) begin
            len++;
            tick();
        end
    endtask

    // Number of consecutive samples (starting now) with pll_rst low.
    task automatic low_len(output int len);
        len = 0;
        while (pll_rst === 1'b0 && len < 200) begin
            len++;
            tick();
        end
    endtask

    // Called on the sample where WAIT_LOCK starts with lock low: lock rises now.
    task automatic relock_full(input string tag);
        pll_locked = 1'b1;
        ticks(10);
        check({tag, "_ready_early"}, 32'(ready), 32'd0);
        tick();
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_sys_rst"}, 32'(sys_rst), 32'd0);
        check({tag, "_retry"}, 32'(retry_count), 32'd0);
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd0);
    endtask

    // Called on the sample where WAIT_LOCK starts with lock already synchronized high.
    task automatic run_from_fall(input string tag);
        ticks(8);
        check({tag, "_ready_early"}, 32'(ready), 32'd0);
        tick();
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_retry"}, 32'(retry_count), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_retry"}, 32'(retry_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        ticks(3);
        check_reset_vals("reset");

        // Bring-up with lock arriving 10 cycles after pll_rst falls.
        rst = 1'b0;
        high_len(n);
        check("t1_pll_rst_len", 32'(n), 32'd4);
        check("t1_sys_rst_wait", 32'(sys_rst), 32'd1);
        ticks(10);
        relock_full("t1");

        // Lock loss in RUN.
        ticks(3);
        pll_locked = 1'b0;
        ticks(2);
        check("t4_ready_hold", 32'(ready), 32'd1);
        tick();
        check("t4_ready_drop", 32'(ready), 32'd0);
        check("t4_sys_rst", 32'(sys_rst), 32'd1);
        check("t4_pll_rst", 32'(pll_rst), 32'd1);
        high_len(n);
        check("t4_pll_rst_len", 32'(n), 32'd4);
        check("t4_retry", 32'(retry_count), 32'd0);
        relock_full("t4");

        // Relock request coincident with synchronized lock falling: one pulse only.
        ticks(3);
        pll_locked = 1'b0;
        ticks(2);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("t5b_pll_rst", 32'(pll_rst), 32'd1);
        high_len(n);
        check("t5b_pll_rst_len", 32'(n), 32'd4);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pll_rst === 1'b1) hi++;
        end
        check("t5b_extra_pulse", 32'(hi), 32'd0);
        relock_full("t5b");

        // One-cycle lock glitch in STABLE counts as a failed attempt.
        ticks(3);
        pll_locked = 1'b0;
        ticks(3);
        check("t3_pll_rst", 32'(pll_rst), 32'd1);
        high_len(n);
        pll_locked = 1'b1;
        ticks(6);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        check("t3_pre_fail_pll_rst", 32'(pll_rst), 32'd0);
        check("t3_pre_fail_retry", 32'(retry_count), 32'd0);
        tick();
        check("t3_fail_pll_rst", 32'(pll_rst), 32'd1);
        check("t3_fail_retry", 32'(retry_count), 32'd1);
        high_len(n);
        check("t3_retry_pulse_len", 32'(n), 32'd4);
        ticks(8);
        check("t3_ready_early", 32'(ready), 32'd0);
        check("t3_retry_held", 32'(retry_count), 32'd1);
        tick();
        check("t3_ready", 32'(ready), 32'd1);
        check("t3_retry_cleared", 32'(retry_count), 32'd0);

        // Lock never returns: three attempts then FAULT.
        ticks(3);
        pll_locked = 1'b0;
        ticks(3);
        check("t2_pll_rst", 32'(pll_rst), 32'd1);
        high_len(n);
        check("t2_pulse0_len", 32'(n), 32'd4);
        check("t2_retry0", 32'(retry_count), 32'd0);
        low_len(n);
        check("t2_wait0_len", 32'(n), 32'd32);
        check("t2_retry1", 32'(retry_count), 32'd1);
        high_len(n);
        check("t2_pulse1_len", 32'(n), 32'd4);
        low_len(n);
        check("t2_wait1_len", 32'(n), 32'd32);
        check("t2_retry2", 32'(retry_count), 32'd2);
        high_len(n);
        check("t2_pulse2_len", 32'(n), 32'd4);
        low_len(n);
        check("t2_wait2_len", 32'(n), 32'd32);
        check("t2_fault", 32'(fault), 32'd1);
        check("t2_fault_pll_rst", 32'(pll_rst), 32'd1);
        check("t2_fault_sys_rst", 32'(sys_rst), 32'd1);
        check("t2_fault_ready", 32'(ready), 32'd0);
        check("t2_fault_retry", 32'(retry_count), 32'd2);
        ticks(20);
        check("t2_fault_sticky", 32'(fault), 32'd1);
        check("t2_fault_pll_rst_held", 32'(pll_rst), 32'd1);

        // Relock request clears FAULT and restarts.
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("t5a_fault", 32'(fault), 32'd0);
        check("t5a_retry", 32'(retry_count), 32'd0);
        check("t5a_pll_rst", 32'(pll_rst), 32'd1);
        check("t5a_sys_rst", 32'(sys_rst), 32'd1);
        high_len(n);
        check("t5a_pll_rst_len", 32'(n), 32'd4);
        relock_full("t5a");

        // rst mid WAIT_LOCK after one failed attempt.
        ticks(3);
        pll_locked = 1'b0;
        ticks(3);
        high_len(n);
        low_len(n);
        high_len(n);
        ticks(5);
        check("t6a_retry_before", 32'(retry_count), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("t6a");
        high_len(n);
        check("t6a_pll_rst_len", 32'(n), 32'd4);
        relock_full("t6a");

        // rst mid STABLE.
        ticks(3);
        pll_locked = 1'b0;
        ticks(3);
        high_len(n);
        pll_locked = 1'b1;
        ticks(5);
        check("t6b_in_stable", 32'(pll_rst), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("t6b");
        high_len(n);
        check("t6b_pll_rst_len", 32'(n), 32'd4);
        run_from_fall("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
